ov7670_stream_gen: RTL and testbench
====================================

OV7670_STREAM_GEN -- requirements
Module: ov7670_stream_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 640, active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480, active lines per frame.
REQ-003 SHALL have parameter HBLANK, default 144, clocks with href low after each active line.
REQ-004 SHALL have parameters VSYNC_LINES, VBP_LINES and VFP_LINES, defaults 3, 17 and 10, measured in line periods.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  single clock; one output byte per cycle.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 enable  in  1  run frames while high.
REQ-009 pattern_sel  in  2  00 external, 01 colour bars, 10 horizontal ramp, 11 solid.
REQ-010 solid_rgb  in  12  RGB444 value used by pattern 11.
REQ-011 pixel_in  in  12  external RGB444 pixel.
REQ-012 pixel_req  out  1  strobe requesting the next external pixel.
REQ-013 vsync  out  1  OV7670-style frame sync, active high.
REQ-014 href  out  1  high while active bytes are on d.
REQ-015 d  out  8  pixel byte stream.
REQ-016 frame_done  out  1  one-cycle pulse at the end of each frame.

Function
REQ-017 SHALL define LINE_LEN as 2*IMG_W+HBLANK cycles.
REQ-018 SHALL implement the FSM IDLE -> VSYNC -> VBP -> ACTIVE -> VFP -> (VSYNC if enable, else IDLE).
REQ-019 SHALL leave IDLE on the first cycle enable is sampled high.
REQ-020 In VSYNC, vsync SHALL be high for exactly VSYNC_LINES*LINE_LEN cycles; in all other states vsync SHALL be low.
REQ-021 VBP SHALL last VBP_LINES*LINE_LEN cycles and VFP SHALL last VFP_LINES*LINE_LEN cycles, with href low throughout both.
REQ-022 ACTIVE SHALL contain IMG_H lines; each line is href high for 2*IMG_W cycles followed by href low for HBLANK cycles.
REQ-023 Each pixel SHALL occupy two consecutive href-high cycles: first byte {4'h0, R[3:0]}, second byte {G[3:0], B[3:0]}.
REQ-024 d SHALL be 8'h00 whenever href is low.
REQ-025 pixel_req SHALL be high for one cycle, one cycle before each first byte; pixel_in is sampled at the edge ending that cycle.
REQ-026 pixel_req SHALL be low outside ACTIVE and during the second byte of each pixel.
REQ-027 Colour bars: 8 equal-width bars in order white, yellow, cyan, green, magenta, red, blue, black (FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000); bar index = x*8/IMG_W.
REQ-028 Ramp: R=G=B=x[3:0], where x is the pixel column.
REQ-029 Solid: every pixel SHALL equal solid_rgb.
REQ-030 pattern_sel and solid_rgb SHALL be latched on VSYNC entry and held constant for the whole frame.
REQ-031 Deasserting enable mid-frame SHALL complete the current frame through VFP, then enter IDLE; no partial frames.
REQ-032 frame_done SHALL pulse in the last VFP cycle.
REQ-033 The x, line and state counters SHALL wrap cleanly; no count exceeds its phase length.

Reset
REQ-034 While rst_n is low: state=IDLE, all counters 0, and vsync, href, d, pixel_req, frame_done all 0.
REQ-035 Asserting rst_n mid-frame SHALL abort the frame immediately with no further output.
REQ-036 After rst_n rises, the block SHALL start a fresh frame at VSYNC entry only if enable is high.

Configuration
REQ-037 Macro OV7670_STREAM_GEN_PATTERN_EN defined: the internal pattern generator is built, and pattern_sel and solid_rgb behave as specified.
REQ-038 Macro OV7670_STREAM_GEN_PATTERN_EN undefined: the pattern logic is removed, pattern_sel and solid_rgb are ignored, and pixels always come from pixel_in.

Verification (IMG_W=8, IMG_H=4, HBLANK=4, VSYNC_LINES=VBP_LINES=VFP_LINES=1; LINE_LEN=20)
REQ-039 Timing: enable=1, pattern 11 -> vsync high 20 cycles, 20 idle cycles, 4 lines of 16 href-high + 4 low, 20 VFP cycles, frame_done after 140 cycles.
REQ-040 Solid: solid_rgb=12'hA5C -> bytes alternate 0A, 5C for every active pixel; d=00 whenever href is low.
REQ-041 External source: pattern 00, pixel_in = number of pixel_req pulses seen so far -> 32 pixel_req pulses per frame, each one cycle ahead of its first byte; bytes 00,00,00,01,00,02,...
REQ-042 Bars: pattern 01 with the macro defined -> line byte pairs 0F/FF, 0F/F0, 00/FF, 00/F0, 0F/0F, 0F/00, 00/0F, 00/00.
REQ-043 Mid-frame stop: enable dropped during line 2 -> frame finishes, frame_done pulses, state IDLE, no further vsync.
REQ-044 Mid-frame reset: rst_n pulsed low during ACTIVE -> all outputs 0 at once; restart begins with a full vsync phase.

Source files
------------

// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen
// Produces an OV7670-style RGB444 byte stream: vsync, href and one byte per
// clock on d. Each frame runs vsync, vertical back porch, IMG_H active lines
// and vertical front porch. Each active line is 2*IMG_W bytes with href high,
// followed by HBLANK clocks with href low. Every pixel is sent as two bytes:
// {4'h0, R} first, then {G, B}.
//
// Optional build macro: OV7670_STREAM_GEN_PATTERN_EN
//   When defined, an internal pattern generator is built. pattern_sel selects
//   the pixel source: 00 external, 01 colour bars, 10 ramp, 11 solid_rgb.
//   When undefined, pattern_sel and solid_rgb are ignored and every pixel
//   comes from pixel_in.
//
// Ports:
//   clk          single clock, one output byte per cycle
//   rst_n        asynchronous active-low reset
//   enable       run frames while high; it is sampled at frame boundaries
//   pattern_sel  pixel source select, latched on VSYNC entry
//   solid_rgb    RGB444 colour for the solid pattern, latched on VSYNC entry
//   pixel_in     external RGB444 pixel, sampled at the end of a pixel_req cycle
//   pixel_req    one-cycle strobe, one cycle before each pixel's first byte
//   vsync        frame sync, active high
//   href         high while active bytes are on d
//   d            pixel byte stream, 8'h00 while href is low
//   frame_done   one-cycle pulse in the last front-porch cycle
module ov7670_stream_gen #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int HBLANK      = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_rgb,
  input  logic [11:0] pixel_in,
  output logic        pixel_req,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_done
);

  localparam int LINE_LEN  = 2 * IMG_W + HBLANK;
  localparam int XW        = $clog2(LINE_LEN + 1);
  localparam int MAX_LINES = (IMG_H > VBP_LINES)
                             ? ((IMG_H > VFP_LINES) ? ((IMG_H > VSYNC_LINES) ? IMG_H : VSYNC_LINES)
                                                    : ((VFP_LINES > VSYNC_LINES) ? VFP_LINES : VSYNC_LINES))
                             : ((VBP_LINES > VFP_LINES) ? ((VBP_LINES > VSYNC_LINES) ? VBP_LINES : VSYNC_LINES)
                                                        : ((VFP_LINES > VSYNC_LINES) ? VFP_LINES : VSYNC_LINES));
  localparam int LW        = $clog2(MAX_LINES + 1);

  localparam logic [XW-1:0] X_LAST      = XW'(LINE_LEN - 1);
  localparam logic [XW-1:0] ACT_BYTES   = XW'(2 * IMG_W);
  localparam logic [XW-1:0] LAST_REQ_X  = XW'(2 * IMG_W - 1);
  localparam logic [LW-1:0] VS_LAST     = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VBP_LAST    = LW'(VBP_LINES - 1);
  localparam logic [LW-1:0] ACT_LAST    = LW'(IMG_H - 1);
  localparam logic [LW-1:0] VFP_LAST    = LW'(VFP_LINES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } state_t;

  state_t        state, nxt_state;
  logic [XW-1:0] x_cnt, nxt_x;
  logic [LW-1:0] line_cnt, nxt_line;
  logic [LW-1:0] phase_last;
  logic          line_end, phase_end;
  logic          nxt_href, nxt_req, nxt_done;
  logic [7:0]    lo_byte;
  logic [11:0]   pix_col;

  // Next-cycle state and counters. Every non-idle phase is a whole number of
  // line periods, so one x counter and one line counter time all of them.
  // The output registers below are loaded from these next-cycle values, which
  // keeps every output registered yet aligned with the state it belongs to.
  always_comb begin
    nxt_state = state;
    nxt_x     = x_cnt;
    nxt_line  = line_cnt;
    case (state)
      ST_VSYNC:  phase_last = VS_LAST;
      ST_VBP:    phase_last = VBP_LAST;
      ST_ACTIVE: phase_last = ACT_LAST;
      ST_VFP:    phase_last = VFP_LAST;
      default:   phase_last = '0;
    endcase
    line_end  = (x_cnt == X_LAST);
    phase_end = line_end && (line_cnt == phase_last);

    if (state != ST_IDLE) begin
      nxt_x = line_end ? '0 : x_cnt + 1'b1;
      if (phase_end)     nxt_line = '0;
      else if (line_end) nxt_line = line_cnt + 1'b1;
    end

    case (state)
      ST_IDLE:   if (enable)    nxt_state = ST_VSYNC;
      ST_VSYNC:  if (phase_end) nxt_state = ST_VBP;
      ST_VBP:    if (phase_end) nxt_state = ST_ACTIVE;
      ST_ACTIVE: if (phase_end) nxt_state = ST_VFP;
      ST_VFP:    if (phase_end) nxt_state = enable ? ST_VSYNC : ST_IDLE;
      default:   nxt_state = ST_IDLE;
    endcase

    nxt_href = (nxt_state == ST_ACTIVE) && (nxt_x < ACT_BYTES);
    // The request precedes every first byte: inside a line it lands on the
    // previous pixel's second byte; for pixel 0 it is the last cycle of the
    // preceding line, or of the back porch for the first line.
    nxt_req  = ((nxt_state == ST_ACTIVE) && nxt_x[0] && (nxt_x < LAST_REQ_X))
            || ((nxt_x == X_LAST) && (((nxt_state == ST_ACTIVE) && (nxt_line != ACT_LAST))
                                   || ((nxt_state == ST_VBP) && (nxt_line == VBP_LAST))));
    nxt_done = (nxt_state == ST_VFP) && (nxt_x == X_LAST) && (nxt_line == VFP_LAST);
  end

`ifdef OV7670_STREAM_GEN_PATTERN_EN
  logic [1:0]  pat_q;
  logic [11:0] solid_q;
  logic [15:0] px;
  logic [2:0]  bar_idx;

  // Pixel colour for the column about to be sent; px is the column of the
  // next cycle's byte pair.
  always_comb begin
    px      = 16'(nxt_x >> 1);
    bar_idx = 3'((32'(px) * 32'd8) / 32'(IMG_W));
    case (pat_q)
      2'b01: begin
        case (bar_idx)
          3'd0:    pix_col = 12'hFFF;
          3'd1:    pix_col = 12'hFF0;
          3'd2:    pix_col = 12'h0FF;
          3'd3:    pix_col = 12'h0F0;
          3'd4:    pix_col = 12'hF0F;
          3'd5:    pix_col = 12'hF00;
          3'd6:    pix_col = 12'h00F;
          default: pix_col = 12'h000;
        endcase
      end
      2'b10:   pix_col = {px[3:0], px[3:0], px[3:0]};
      2'b11:   pix_col = solid_q;
      default: pix_col = pixel_in;
    endcase
  end

  // Pattern controls are captured once per frame so a frame never mixes
  // sources even if the inputs move while it is being sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= 2'b00;
      solid_q <= 12'h000;
    end else if ((state != ST_VSYNC) && (nxt_state == ST_VSYNC)) begin
      pat_q   <= pattern_sel;
      solid_q <= solid_rgb;
    end
  end
`else
  logic unused_pattern_inputs;
  assign unused_pattern_inputs = ^{pattern_sel, solid_rgb};
  assign pix_col = pixel_in;
`endif

  // Single FSM register: state, counters and all registered outputs.
  // The low byte is held from the first-byte edge because pixel_in is only
  // guaranteed valid at the edge that ends the request cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      x_cnt      <= '0;
      line_cnt   <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= 8'h00;
      pixel_req  <= 1'b0;
      frame_done <= 1'b0;
      lo_byte    <= 8'h00;
    end else begin
      state      <= nxt_state;
      x_cnt      <= nxt_x;
      line_cnt   <= nxt_line;
      vsync      <= (nxt_state == ST_VSYNC);
      href       <= nxt_href;
      pixel_req  <= nxt_req;
      frame_done <= nxt_done;
      if (nxt_href) begin
        if (!nxt_x[0]) begin
          d       <= {4'h0, pix_col[11:8]};
          lo_byte <= pix_col[7:0];
        end else begin
          d       <= lo_byte;
        end
      end else begin
        d <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb_ov7670_stream_gen
// Self-checking bench for ov7670_stream_gen with a small frame
// (8x4 pixels, 4 blanking clocks, one line each of vsync, back and front
// porch; 20-clock lines, 140-clock frames). Expected outputs for every cycle
// of a frame come from a reference model computed from the frame geometry.
// The bench follows the OV7670_STREAM_GEN_PATTERN_EN macro so the model
// matches whichever build is compiled.
module tb_ov7670_stream_gen;

  localparam int IMG_W     = 8;
  localparam int IMG_H     = 4;
  localparam int HBLANK    = 4;
  localparam int VS_L      = 1;
  localparam int VBP_L     = 1;
  localparam int VFP_L     = 1;
  localparam int LINE_LEN  = 2 * IMG_W + HBLANK;
  localparam int FRAME_LEN = (VS_L + VBP_L + IMG_H + VFP_L) * LINE_LEN;
  localparam int NPIX      = IMG_W * IMG_H;
`ifdef OV7670_STREAM_GEN_PATTERN_EN
  localparam bit PATTERN_EN = 1'b1;
`else
  localparam bit PATTERN_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [11:0] solid_rgb;
  logic [11:0] pixel_in;
  logic        pixel_req;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic        frame_done;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] ext_pix [NPIX];
  int          req_seen;
  logic [1:0]  rnd_pat, rnd_pat2;
  logic [11:0] rnd_solid, rnd_solid2;

  ov7670_stream_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .HBLANK(HBLANK),
    .VSYNC_LINES(VS_L), .VBP_LINES(VBP_L), .VFP_LINES(VFP_L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .pixel_in(pixel_in), .pixel_req(pixel_req),
    .vsync(vsync), .href(href), .d(d), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External pixel source: presents ext_pix[n] during the n-th request of the
  // frame, so the requested pixel is stable at the sampling edge.
  initial begin
    req_seen = 0;
    pixel_in = 12'h000;
    forever begin
      @(negedge clk);
      if (!rst_n || vsync) req_seen = 0;
      pixel_in = ext_pix[req_seen % NPIX];
      if (pixel_req) req_seen++;
    end
  end

  task automatic checkOutput(input string tag, input logic [11:0] observed,
                             input logic [11:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed {vs,href,req,done,d}=%h expected %h",
             tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] pat,
                               input logic [11:0] solid);
    enable      = en;
    pattern_sel = pat;
    solid_rgb   = solid;
  endtask

  task automatic fill_ext(input bit counting);
    for (int k = 0; k < NPIX; k++)
      ext_pix[k] = counting ? 12'(k) : 12'($urandom);
  endtask

  function automatic logic [11:0] model_colour(input logic [1:0] pat,
                                               input logic [11:0] solid,
                                               input int line, input int p);
    logic [3:0] r4;
    int         bar;
    r4  = 4'(p);
    bar = p * 8 / IMG_W;
    if (PATTERN_EN && pat == 2'b01) begin
      case (bar)
        0:       return 12'hFFF;
        1:       return 12'hFF0;
        2:       return 12'h0FF;
        3:       return 12'h0F0;
        4:       return 12'hF0F;
        5:       return 12'hF00;
        6:       return 12'h00F;
        default: return 12'h000;
      endcase
    end
    if (PATTERN_EN && pat == 2'b10) return {r4, r4, r4};
    if (PATTERN_EN && pat == 2'b11) return solid;
    return ext_pix[line * IMG_W + p];
  endfunction

  // Expected {vsync, href, pixel_req, frame_done, d} for frame cycle c.
  function automatic logic [11:0] model_out(input int c, input logic [1:0] pat,
                                            input logic [11:0] solid);
    int          vs_end, vbp_end, act_end, a, line, x;
    logic        h, req;
    logic [7:0]  byte_v;
    logic [11:0] col;
    vs_end  = VS_L * LINE_LEN;
    vbp_end = vs_end + VBP_L * LINE_LEN;
    act_end = vbp_end + IMG_H * LINE_LEN;
    if (c < vs_end) return 12'h800;
    if (c < vbp_end) return {2'b00, (c == vbp_end - 1), 9'h000};
    if (c < act_end) begin
      a      = c - vbp_end;
      line   = a / LINE_LEN;
      x      = a % LINE_LEN;
      h      = (x < 2 * IMG_W);
      req    = ((x + 1 < 2 * IMG_W) && ((x + 1) % 2 == 0))
            || ((x == LINE_LEN - 1) && (line < IMG_H - 1));
      byte_v = 8'h00;
      if (h) begin
        col    = model_colour(pat, solid, line, x / 2);
        byte_v = (x % 2 == 0) ? {4'h0, col[11:8]} : col[7:0];
      end
      return {1'b0, h, req, 1'b0, byte_v};
    end
    return {3'b000, (c == FRAME_LEN - 1), 8'h00};
  endfunction

  // Checks one frame cycle by cycle from its first VSYNC cycle. Optional
  // mid-frame actions happen right after the check of the named cycle.
  task automatic check_frame(input string name, input logic [1:0] pat,
                             input logic [11:0] solid, input int chg_at,
                             input logic [1:0] new_pat, input logic [11:0] new_solid,
                             input int drop_at, input int reset_at);
    for (int c = 0; c < FRAME_LEN; c++) begin
      @(negedge clk);
      checkOutput($sformatf("%s c%0d", name, c),
                  {vsync, href, pixel_req, frame_done, d}, model_out(c, pat, solid));
      if (c == chg_at) applyStimulus(enable, new_pat, new_solid);
      if (c == drop_at) enable = 1'b0;
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        checkOutput($sformatf("%s reset abort", name),
                    {vsync, href, pixel_req, frame_done, d}, 12'h000);
        break;
      end
    end
  endtask

  task automatic check_quiet(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s %0d", name, i),
                  {vsync, href, pixel_req, frame_done, d}, 12'h000);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'b00, 12'h000);
    fill_ext(1'b1);
    check_quiet("reset", 2);
    enable = 1'b1;
    check_quiet("reset with enable", 2);
    enable = 1'b0;
    rst_n  = 1'b1;
    check_quiet("idle", 5);

    // Solid A5C; pattern inputs change mid-frame but only apply next frame.
    applyStimulus(1'b1, 2'b11, 12'hA5C);
    check_frame("solid", 2'b11, 12'hA5C, 30, 2'b00, 12'h123, -1, -1);
    fill_ext(1'b1);
    check_frame("ext count", 2'b00, 12'h123, 60, 2'b01, 12'h456, -1, -1);
    check_frame("bars", 2'b01, 12'h456, 90, 2'b10, 12'h789, -1, -1);
    rnd_pat   = 2'($urandom_range(0, 3));
    rnd_solid = 12'($urandom);
    check_frame("ramp", 2'b10, 12'h789, 130, rnd_pat, rnd_solid, -1, -1);

    // Random source; enable drops during active line 2.
    fill_ext(1'b0);
    rnd_pat2   = 2'($urandom_range(0, 3));
    rnd_solid2 = 12'($urandom);
    check_frame("stop", rnd_pat, rnd_solid, 50, rnd_pat2, rnd_solid2, 85, -1);
    check_quiet("after stop", 30);

    // Restart, then reset during the active region.
    fill_ext(1'b0);
    rnd_pat   = 2'($urandom_range(0, 3));
    rnd_solid = 12'($urandom);
    applyStimulus(1'b1, rnd_pat, rnd_solid);
    check_frame("pre reset", rnd_pat, rnd_solid, -1, 2'b00, 12'h000, -1, 70);
    check_quiet("in reset", 3);

    // Fresh frame after reset must begin with a full vsync phase.
    fill_ext(1'b0);
    rnd_pat   = 2'($urandom_range(0, 3));
    rnd_solid = 12'($urandom);
    applyStimulus(1'b1, rnd_pat, rnd_solid);
    rst_n = 1'b1;
    check_frame("post reset", rnd_pat, rnd_solid, -1, 2'b00, 12'h000, FRAME_LEN - 1, -1);
    check_quiet("final idle", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
